// File: rtl/vga_score_display.sv
// vga_score_display: binary value -> sequential double-dabble BCD -> N-digit glyph overlay on the VGA colour stream
module vga_score_display #(
  parameter int          NUM_DIGITS = 6,
  parameter int          VALUE_W    = 20,
  parameter int          GLYPH_W    = 12,
  parameter int          GLYPH_H    = 17,
  parameter int          DIGIT_GAP  = 2,
  parameter int          X0         = 16,
  parameter int          Y0         = 8,
  parameter logic [11:0] FG_RGB     = 12'hFFF,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               value_valid,
  output logic               value_ready,
  output logic               busy,
  input  logic [31:0]        x,
  input  logic [31:0]        y,
  input  logic [3:0]         background_red,
  input  logic [3:0]         background_green,
  input  logic [3:0]         background_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);
  localparam int PITCH = GLYPH_W + DIGIT_GAP;
  localparam int BW    = NUM_DIGITS * 4;
  localparam int CW    = $clog2(VALUE_W + 1);
  localparam int T     = 2;
  localparam int HM    = GLYPH_H / 2;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t               r_state, w_next;
  logic [VALUE_W-1:0]   r_bin;
  logic [BW-1:0]        r_bcd, r_disp, w_adj;
  logic                 r_ovf;
  logic [CW-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                 w_run, w_in, w_blk, w_fg;
  logic [31:0]          w_dx, w_dy, w_d, w_col;
  logic [3:0]           w_digit;

  // Seven-segment-style glyph table: segment masks {g,f,e,d,c,b,a} mapped onto the GLYPH_W x GLYPH_H cell
  function automatic logic glyph_on(input logic [3:0] dig, input logic [31:0] row, input logic [31:0] col);
    logic [6:0] seg;
    logic hz, lf, rt, up, lo;
    case (dig)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    hz = (col >= 32'(T)) && (col < 32'(GLYPH_W - T));
    lf = col < 32'(T);
    rt = col >= 32'(GLYPH_W - T);
    up = row <= 32'(HM);
    lo = row >= 32'(HM);
    return (seg[0] && hz && row < 32'(T)) ||
           (seg[1] && rt && up) ||
           (seg[2] && rt && lo) ||
           (seg[3] && hz && row >= 32'(GLYPH_H - T)) ||
           (seg[4] && lf && lo) ||
           (seg[5] && lf && up) ||
           (seg[6] && hz && row >= 32'(HM - 1) && row <= 32'(HM + 1));
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;

  // FSM next state: SHIFT lasts exactly VALUE_W cycles, COMMIT one
  always_comb
    w_next = (r_state == S_IDLE)  ? (value_valid ? S_SHIFT : S_IDLE) :
             (r_state == S_SHIFT) ? ((r_cnt == CW'(VALUE_W - 1)) ? S_COMMIT : S_SHIFT) :
                                    S_IDLE;

  // FSM outputs
  always_comb begin
    value_ready = r_state == S_IDLE;
    busy        = r_state != S_IDLE;
  end

  // Add-3 correction on every nibble >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++)
      w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
  end

  // Conversion datapath; a bit shifted out of the top nibble means value >= 10^NUM_DIGITS
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_disp <= '0;
    end else if (r_state == S_IDLE) begin
      if (value_valid) begin
        r_bin <= value_in;
        r_bcd <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end
    end else if (r_state == S_SHIFT) begin
      r_bcd <= {w_adj[BW-2:0], r_bin[VALUE_W-1]};
      r_ovf <= r_ovf | w_adj[BW-1];
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_disp <= r_ovf ? {NUM_DIGITS{4'h9}} : r_bcd;
    end

  // Leading-zero blanking; digit 0 is the most significant nibble, the last digit is never blanked
  always_comb begin
    w_run   = 1'b1;
    w_blank = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_run      = w_run && (r_disp[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      w_blank[d] = BLANK_LZ && w_run && (d < NUM_DIGITS - 1);
    end
  end

  // Pixel hit test: region, digit cell, gap column and glyph bit
  always_comb begin
    w_dx    = x - 32'(X0);
    w_dy    = y - 32'(Y0);
    w_in    = (x >= 32'(X0)) && (x < 32'(X0 + NUM_DIGITS * PITCH)) &&
              (y >= 32'(Y0)) && (y < 32'(Y0 + GLYPH_H));
    w_d     = w_dx / 32'(PITCH);
    w_col   = w_dx % 32'(PITCH);
    w_digit = '0;
    w_blk   = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (w_d == 32'(d)) begin
        w_digit = r_disp[4*(NUM_DIGITS-1-d) +: 4];
        w_blk   = w_blank[d];
      end
    w_fg = w_in && (w_col < 32'(GLYPH_W)) && !w_blk && glyph_on(w_digit, w_dy, w_col);
  end

  // Registered colour mux
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= w_fg ? FG_RGB[11:8] : background_red;
      green <= w_fg ? FG_RGB[7:4]  : background_green;
      blue  <= w_fg ? FG_RGB[3:0]  : background_blue;
    end
endmodule

// File: tb/tb_vga_score_display.sv
// tb_vga_score_display: directed checks of conversion timing, saturation, handshake and glyph rendering
module tb_vga_score_display;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] value_in;
  logic        value_valid;
  logic        value_ready, busy;
  logic [31:0] x, y;
  logic [3:0]  red, green, blue;
  logic [11:0] rgb;
  int          total = 0;
  int          bad = 0;

  assign rgb = {red, green, blue};

  vga_score_display dut (
    .clk(clk), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .value_ready(value_ready), .busy(busy), .x(x), .y(y),
    .background_red(BG[11:8]), .background_green(BG[7:4]), .background_blue(BG[3:0]),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int px, input int py, input logic [11:0] exp, input string tag);
    x = 32'(px);
    y = 32'(py);
    tick;
    chk(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic send(input logic [19:0] v);
    value_in    = v;
    value_valid = 1'b1;
    tick;
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(input int exp_n, input string tag);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    reset = 1'b1; value_in = '0; value_valid = 1'b0; x = '0; y = '0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_ready", 32'(value_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) tick;
    reset = 1'b0;
    pix(88, 8, FG, "zero_d5_top");
    pix(74, 8, BG, "zero_d4_blank");
    pix(91, 16, BG, "zero_d5_centre");
    // reset asserted mid-frame clears colour without waiting for a clock
    x = 88; y = 8;
    tick;
    chk("pre_rst_rgb", 32'(rgb), 32'(FG));
    #2 reset = 1'b1;
    #1 chk("async_rst_rgb", 32'(rgb), 32'h0);
    tick;
    reset = 1'b0;
    chk("post_rst_ready", 32'(value_ready), 32'd1);
    // 12345 -> busy 21 cycles, displays 012345 with digit 0 blanked
    send(20'd12345);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_notready", 32'(value_ready), 32'd0);
    wait_idle(21, "t2_busy_cycles");
    chk("t2_ready", 32'(value_ready), 32'd1);
    pix(18, 8, BG, "t2_d0_blank");
    pix(40, 11, FG, "t2_d1_one_b");
    pix(32, 8, BG, "t2_d1_one_a");
    pix(96, 11, BG, "t2_d5_five_b");
    pix(86, 11, FG, "t2_d5_five_f");
    // 1048575 saturates; old value stays on screen mid-conversion
    send(20'd1048575);
    pix(18, 8, BG, "t3_mid_old");
    wait_idle(20, "t3_busy_cycles");
    pix(18, 8, FG, "t3_d0_nine_a");
    pix(16, 20, BG, "t3_d0_nine_e");
    // 1000000 is the first saturating value
    send(20'd1000000);
    wait_idle(21, "t3b_busy_cycles");
    pix(18, 8, FG, "t3b_sat_d0");
    pix(86, 20, BG, "t3b_sat_d5_e");
    // valid held through conversion: second value only taken once ready again
    value_in = 20'd7; value_valid = 1'b1;
    tick;
    value_in = 20'd500000;
    wait_idle(21, "t4_first_cycles");
    chk("t4_ready", 32'(value_ready), 32'd1);
    x = 96; y = 20;
    tick;
    chk("t4_seven_c", 32'(rgb), 32'(FG));
    chk("t4_second_taken", 32'(busy), 32'd1);
    value_valid = 1'b0;
    wait_idle(21, "t4_second_cycles");
    pix(16, 11, FG, "t4_d0_five_f");
    pix(26, 11, BG, "t4_d0_five_b");
    pix(32, 8, FG, "t4_d1_zero_a");
    pix(88, 8, FG, "t4_d5_zero_a");
    // sweep at y=Y0+5 over 888888
    send(20'd888888);
    wait_idle(21, "t5_busy_cycles");
    pix(15, 13, BG, "t5_left_edge");
    pix(28, 13, BG, "t5_gap_col");
    pix(97, 13, FG, "t5_d5_col11");
    pix(98, 13, BG, "t5_d5_gap");
    pix(100, 13, BG, "t5_right_edge");
    pix(32'hFFFF_FFF0, 13, BG, "t5_no_wrap");
    x = 49; y = 16;
    #1 chk("t5_latency_hold", 32'(rgb), 32'(BG));
    tick;
    chk("t5_eight_centre", 32'(rgb), 32'(FG));
    // reset during SHIFT aborts with no stale commit
    send(20'd123456);
    repeat (5) tick;
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(value_ready), 32'd1);
    chk("t6_rgb", 32'(rgb), 32'h0);
    #3 reset = 1'b0;
    repeat (30) tick;
    chk("t6_idle", 32'(busy), 32'd0);
    pix(74, 8, BG, "t6_d4_blank");
    pix(88, 8, FG, "t6_d5_zero");
    pix(18, 8, BG, "t6_d0_blank");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
